// File: rtl/risc_pkg.sv
// Shared RISC core definitions: instruction field layout, HALT opcode and
// the fetch-unit state encoding.
package risc_pkg;

  localparam int OPCODE_W = 4;
  localparam int OPR1_W   = 4;
  localparam int OPR2_W   = 8;
  localparam int INSTR_W  = 16;

  localparam int OPCODE_MSB = 15;
  localparam int OPCODE_LSB = 12;
  localparam int OPR1_MSB   = 11;
  localparam int OPR1_LSB   = 8;
  localparam int OPR2_MSB   = 7;
  localparam int OPR2_LSB   = 0;

  localparam logic [OPCODE_W-1:0] HALT_OPCODE_DEF = 4'hF;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    REQ    = 3'd1,
    WAIT   = 3'd2,
    HOLD   = 3'd3,
    HALTED = 3'd4
  } ifu_state_t;

  typedef enum logic [1:0] {
    PC_HOLD = 2'd0,
    PC_INC  = 2'd1,
    PC_LOAD = 2'd2
  } pc_sel_t;

endpackage

// File: rtl/ifu_pc_reg.sv
// Program counter register: hold, increment (wrapping modulo 2^PC_W) or
// load a branch target.
module ifu_pc_reg
  import risc_pkg::*;
#(
  parameter int PC_W = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  pc_sel_t         sel,
  input  logic [PC_W-1:0] target,
  output logic [PC_W-1:0] pc
);

  always_ff @(posedge clk) begin
    if (rst) begin
      pc <= '0;
    end else begin
      case (sel)
        PC_INC:  pc <= pc + 1'b1;
        PC_LOAD: pc <= target;
        default: pc <= pc;
      endcase
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: PC, synchronous imem read, instruction register and
// valid/ack handshake to the decoder. Define IFU_STALL_CNT_EN to add stall_count.
//
// Handshake: instr_valid stays high with fields stable until the decoder
// raises instr_ack in a cycle where instr_valid is high; that edge consumes
// the instruction. instr_ack while instr_valid is low has no effect.
module instr_fetch_unit
  import risc_pkg::*;
#(
  parameter int                   PC_W        = 8,
  parameter logic [OPCODE_W-1:0]  HALT_OPCODE = HALT_OPCODE_DEF
) (
  input  logic               clk,
  input  logic               rst,
  output logic               imem_en,
  output logic [PC_W-1:0]    imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               instr_ack,
  input  logic               branch_en,
  input  logic [PC_W-1:0]    branch_target,
  output logic [OPCODE_W-1:0] opcode,
  output logic [OPR1_W-1:0]  operand_1,
  output logic [OPR2_W-1:0]  operand_2,
  output logic               instr_valid,
  output logic [PC_W-1:0]    pc,
  output logic               halted,
  output ifu_state_t         state
`ifdef IFU_STALL_CNT_EN
  ,output logic [15:0]       stall_count
`endif
);

  ifu_state_t state_d;
  pc_sel_t    pc_sel;
  logic       load_fields;
  logic       valid_d;
  logic       halted_d;

  ifu_pc_reg #(.PC_W(PC_W)) u_pc_reg (
    .clk    (clk),
    .rst    (rst),
    .sel    (pc_sel),
    .target (branch_target),
    .pc     (pc)
  );

  assign imem_en   = (state == REQ);
  assign imem_addr = pc;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      instr_valid <= 1'b0;
      halted      <= 1'b0;
    end else begin
      state       <= state_d;
      instr_valid <= valid_d;
      halted      <= halted_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      opcode    <= '0;
      operand_1 <= '0;
      operand_2 <= '0;
    end else if (load_fields) begin
      opcode    <= imem_rdata[OPCODE_MSB:OPCODE_LSB];
      operand_1 <= imem_rdata[OPR1_MSB:OPR1_LSB];
      operand_2 <= imem_rdata[OPR2_MSB:OPR2_LSB];
    end
  end

  // Branch has priority everywhere it is honoured; it squashes the in-flight
  // read or the held instruction, including a held HALT.
  always_comb begin
    state_d     = state;
    pc_sel      = PC_HOLD;
    load_fields = 1'b0;
    valid_d     = instr_valid;
    halted_d    = halted;
    case (state)
      IDLE: state_d = REQ;
      REQ: begin
        if (branch_en) begin
          pc_sel  = PC_LOAD;
          state_d = REQ;
        end else begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (branch_en) begin
          pc_sel  = PC_LOAD;
          state_d = REQ;
        end else begin
          load_fields = 1'b1;
          valid_d     = 1'b1;
          state_d     = HOLD;
        end
      end
      HOLD: begin
        if (branch_en) begin
          pc_sel  = PC_LOAD;
          valid_d = 1'b0;
          state_d = REQ;
        end else if (instr_ack) begin
          valid_d = 1'b0;
          if (opcode == HALT_OPCODE) begin
            halted_d = 1'b1;
            state_d  = HALTED;
          end else begin
            pc_sel  = PC_INC;
            state_d = REQ;
          end
        end
      end
      HALTED: state_d = HALTED;
      default: begin
        valid_d = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

`ifdef IFU_STALL_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_count <= '0;
    end else if (instr_valid && !instr_ack && (stall_count != 16'hFFFF)) begin
      stall_count <= stall_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with a synchronous-read imem model and
// an expected-instruction queue; covers IFU_STALL_CNT_EN when defined.
module tb_instr_fetch_unit;
  import risc_pkg::*;

  localparam int PC_W = 8;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               imem_en;
  logic [PC_W-1:0]    imem_addr;
  logic [15:0]        imem_rdata = '0;
  logic               instr_ack = 1'b0;
  logic               branch_en = 1'b0;
  logic [PC_W-1:0]    branch_target = '0;
  logic [3:0]         opcode;
  logic [3:0]         operand_1;
  logic [7:0]         operand_2;
  logic               instr_valid;
  logic [PC_W-1:0]    pc;
  logic               halted;
  ifu_state_t         state;
`ifdef IFU_STALL_CNT_EN
  logic [15:0]        stall_count;
`endif

  logic [15:0]        imem [0:255];
  logic [23:0]        exp_q[$];
  int                 n_checks = 0;
  int                 n_fail = 0;
  int                 w;

  instr_fetch_unit #(.PC_W(PC_W)) dut (
    .clk           (clk),
    .rst           (rst),
    .imem_en       (imem_en),
    .imem_addr     (imem_addr),
    .imem_rdata    (imem_rdata),
    .instr_ack     (instr_ack),
    .branch_en     (branch_en),
    .branch_target (branch_target),
    .opcode        (opcode),
    .operand_1     (operand_1),
    .operand_2     (operand_2),
    .instr_valid   (instr_valid),
    .pc            (pc),
    .halted        (halted),
    .state         (state)
`ifdef IFU_STALL_CNT_EN
    ,.stall_count  (stall_count)
`endif
  );

  // clock / memory model: garbage on the read bus whenever no read was issued
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (imem_en) imem_rdata <= imem[imem_addr];
    else         imem_rdata <= 16'($urandom);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic expect_fetch(input logic [7:0] a, input logic [15:0] instr);
    exp_q.push_back({a, instr});
  endtask

  // Waits (bounded) for instr_valid, then pops and compares the scoreboard
  task automatic wait_valid(input int budget, output int waited);
    logic [23:0] e;
    waited = 0;
    while (instr_valid !== 1'b1 && waited < budget) begin
      @(negedge clk);
      waited++;
    end
    if (instr_valid !== 1'b1) begin
      check("valid_timeout", 32'(instr_valid), 32'd1);
    end else if (exp_q.size() == 0) begin
      check("scoreboard_empty", 32'd0, 32'd1);
    end else begin
      e = exp_q.pop_front();
      check("opcode",    32'(opcode),    32'(e[15:12]));
      check("operand_1", 32'(operand_1), 32'(e[11:8]));
      check("operand_2", 32'(operand_2), 32'(e[7:0]));
      check("pc",        32'(pc),        32'(e[23:16]));
    end
  endtask

  task automatic pulse(input logic ack, input logic br, input logic [7:0] tgt);
    instr_ack     = ack;
    branch_en     = br;
    branch_target = tgt;
    @(negedge clk);
    instr_ack = 1'b0;
    branch_en = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_state",  32'(state),       32'(IDLE));
    check("rst_pc",     32'(pc),          32'd0);
    check("rst_en",     32'(imem_en),     32'd0);
    check("rst_addr",   32'(imem_addr),   32'd0);
    check("rst_opcode", 32'(opcode),      32'd0);
    check("rst_opr1",   32'(operand_1),   32'd0);
    check("rst_opr2",   32'(operand_2),   32'd0);
    check("rst_valid",  32'(instr_valid), 32'd0);
    check("rst_halted", 32'(halted),      32'd0);
    rst = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) imem[i] = 16'(i * 16'h0101 + 16'h0011);
    imem[8'h00] = 16'h1234;
    imem[8'h01] = 16'h5678;
    imem[8'h02] = 16'hF000;
    imem[8'h10] = 16'h7A5C;
    imem[8'h20] = 16'h3C0F;
    imem[8'h40] = 16'h2345;
    imem[8'hFF] = 16'hABCD;

    // reset, first fetch and its latency
    do_reset();
    @(negedge clk);
    check("first_state", 32'(state),     32'(REQ));
    check("first_en",    32'(imem_en),   32'd1);
    check("first_addr",  32'(imem_addr), 32'd0);
    expect_fetch(8'h00, 16'h1234);
    wait_valid(8, w);
    check("first_latency", 32'(w), 32'd2);

    pulse(1'b1, 1'b0, 8'h00);
    check("ack_valid", 32'(instr_valid), 32'd0);
    check("ack_pc",    32'(pc),          32'd1);
    check("ack_en",    32'(imem_en),     32'd1);
    check("ack_addr",  32'(imem_addr),   32'd1);
    expect_fetch(8'h01, 16'h5678);
    wait_valid(8, w);
    check("ack_latency", 32'(w), 32'd2);

    // hold stability while ack is withheld and the read bus churns
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("hold_opcode", 32'(opcode),      32'h5);
      check("hold_opr1",   32'(operand_1),   32'h6);
      check("hold_opr2",   32'(operand_2),   32'h78);
      check("hold_pc",     32'(pc),          32'h01);
      check("hold_valid",  32'(instr_valid), 32'd1);
      check("hold_en",     32'(imem_en),     32'd0);
    end
    pulse(1'b1, 1'b0, 8'h00);
    check("ack2_pc", 32'(pc), 32'd2);
    expect_fetch(8'h02, 16'hF000);
    wait_valid(8, w);

    // branch and ack together with HALT held: branch wins
    pulse(1'b1, 1'b1, 8'h40);
    check("coll_halted", 32'(halted),    32'd0);
    check("coll_en",     32'(imem_en),   32'd1);
    check("coll_addr",   32'(imem_addr), 32'h40);
    check("coll_state",  32'(state),     32'(REQ));
    expect_fetch(8'h40, 16'h2345);
    wait_valid(8, w);

    // wrap from 0xFF to 0x00
    pulse(1'b0, 1'b1, 8'hFF);
    expect_fetch(8'hFF, 16'hABCD);
    wait_valid(8, w);
    pulse(1'b1, 1'b0, 8'h00);
    check("wrap_en",   32'(imem_en),   32'd1);
    check("wrap_addr", 32'(imem_addr), 32'h00);
    check("wrap_pc",   32'(pc),        32'h00);
    expect_fetch(8'h00, 16'h1234);
    wait_valid(8, w);

    // ack while invalid is ignored; branch in WAIT squashes the read
    pulse(1'b0, 1'b1, 8'h10);
    pulse(1'b1, 1'b0, 8'h00);
    check("noack_state", 32'(state), 32'(WAIT));
    check("noack_pc",    32'(pc),    32'h10);
    pulse(1'b0, 1'b1, 8'h20);
    check("squash_state", 32'(state),       32'(REQ));
    check("squash_valid", 32'(instr_valid), 32'd0);
    check("squash_pc",    32'(pc),          32'h20);
    expect_fetch(8'h20, 16'h3C0F);
    wait_valid(8, w);
    check("squash_latency", 32'(w), 32'd2);

    // HALT consumed; branch and ack ignored afterwards
    pulse(1'b0, 1'b1, 8'h02);
    expect_fetch(8'h02, 16'hF000);
    wait_valid(8, w);
    pulse(1'b1, 1'b0, 8'h00);
    check("halt_halted", 32'(halted),      32'd1);
    check("halt_valid",  32'(instr_valid), 32'd0);
    check("halt_pc",     32'(pc),          32'd2);
    check("halt_state",  32'(state),       32'(HALTED));
    for (int i = 0; i < 20; i++) begin
      instr_ack     = 1'($urandom_range(0, 1));
      branch_en     = (i == 5 || i == 12);
      branch_target = 8'h33;
      @(negedge clk);
      check("halted_en",    32'(imem_en),     32'd0);
      check("halted_flag",  32'(halted),      32'd1);
      check("halted_valid", 32'(instr_valid), 32'd0);
      check("halted_pc",    32'(pc),          32'd2);
    end
    instr_ack = 1'b0;
    branch_en = 1'b0;
    do_reset();

`ifdef IFU_STALL_CNT_EN
    check("stall_rst", 32'(stall_count), 32'd0);
    expect_fetch(8'h00, 16'h1234);
    wait_valid(8, w);
    repeat (5) @(negedge clk);
    check("stall_5", 32'(stall_count), 32'd5);
    pulse(1'b1, 1'b0, 8'h00);
    check("stall_ack", 32'(stall_count), 32'd5);
    expect_fetch(8'h01, 16'h5678);
    wait_valid(8, w);
    repeat (5) @(negedge clk);
    pulse(1'b1, 1'b0, 8'h00);
    check("stall_10", 32'(stall_count), 32'd10);
    expect_fetch(8'h02, 16'hF000);
    wait_valid(8, w);
    repeat (65540) @(negedge clk);
    check("stall_sat", 32'(stall_count), 32'hFFFF);
    repeat (3) @(negedge clk);
    check("stall_sat_hold", 32'(stall_count), 32'hFFFF);
`else
    @(negedge clk);
`endif

    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
